// File: rtl/shared_buffer_arbiter_if.sv
// Requester/consumer bundle for the shared delay buffer: enable, request words, grants and delayed output.
// master = requester/consumer side, slave = the buffer itself.
interface shared_buffer_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
);
  localparam int ID_W = $clog2(N_REQ);

  logic                      en;
  logic [N_REQ-1:0]          req;
  logic [N_REQ*DATA_W-1:0]   din;
  logic [N_REQ-1:0]          grant;
  logic [DATA_W-1:0]         dout;
  logic                      dout_valid;
  logic [ID_W-1:0]           dout_id;

  modport master (output en, req, din, input grant, dout, dout_valid, dout_id);
  modport slave  (input en, req, din, output grant, dout, dout_valid, dout_id);
endinterface

// File: rtl/shared_buffer_arbiter.sv
// Round-robin (or fixed priority with SHARED_BUF_FIXED_PRIO_EN) admission of one tagged word per cycle into a shared delay line.
// Latency: DEPTH enabled edges from grant to dout; dout is registered.
// Backpressure: en=0 freezes stages and pointer and withholds all grants; requesters hold req/din until granted.
module shared_buffer_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  shared_buffer_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } stage_t;

  stage_t            stage_q [DEPTH];
  logic [ID_W-1:0]   scan_base;
  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic [N_REQ-1:0]  grant_c;
  logic [DATA_W-1:0] win_data;

  // First set request bit in circular order starting at scan_base.
  always_comb begin
    int idx;
    winner  = '0;
    any_req = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(scan_base) + i) % N_REQ;
      if (!any_req && bus.req[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  assign grant_c   = (rst_n && bus.en && any_req) ? (N_REQ'(1) << winner) : '0;
  assign bus.grant = grant_c;
  assign win_data  = bus.din[int'(winner)*DATA_W +: DATA_W];

`ifdef SHARED_BUF_FIXED_PRIO_EN
  assign scan_base = '0;
`else
  logic [ID_W-1:0] ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (bus.en && any_req) begin
      ptr <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + ID_W'(1);
    end
  end

  assign scan_base = ptr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (bus.en) begin
      stage_q[0] <= any_req ? stage_t'{valid: 1'b1, id: winner, data: win_data} : '0;
      for (int k = 1; k < DEPTH; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign bus.dout       = stage_q[DEPTH-1].data;
  assign bus.dout_valid = stage_q[DEPTH-1].valid;
  assign bus.dout_id    = stage_q[DEPTH-1].id;
endmodule

// File: tb/tb_shared_buffer_arbiter.sv
// Directed scenarios plus randomized traffic for shared_buffer_arbiter, checked against a queue-based reference model.
module tb_shared_buffer_arbiter;
  localparam int N_REQ  = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic clk;
  logic rst_n;

  shared_buffer_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

  shared_buffer_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int id;
    int d;
  } word_t;

  int    n_chk;
  int    n_fail;
  int    ptr_m;
  word_t pipe[$];
  logic [N_REQ-1:0]  got_grant;
  logic [DATA_W-1:0] got_dout;
  logic              got_v;
  logic [1:0]        got_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [N_REQ-1:0] r, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    ptr_m = 0;
    pipe.delete();
    for (int k = 0; k < DEPTH; k++) pipe.push_back('{v: 0, id: 0, d: 0});
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic step();
    int    w;
    word_t nw;
    word_t ex;
    @(negedge clk);
    w = bus.en ? model_winner(bus.req, ptr_m) : -1;
    ex = pipe[DEPTH-1];
    got_grant = bus.grant;
    got_dout  = bus.dout;
    got_v     = bus.dout_valid;
    got_id    = bus.dout_id;
    chk("grant", 32'(got_grant), (w >= 0) ? (32'd1 << w) : 32'd0);
    chk("dout_valid", 32'(got_v), 32'(ex.v));
    chk("dout", 32'(got_dout), 32'(ex.d));
    chk("dout_id", 32'(got_id), 32'(ex.id));
    @(posedge clk);
    if (bus.en) begin
      if (w >= 0) begin
        nw = '{v: 1, id: w, d: int'((bus.din >> (w * DATA_W)) & 32'hFF)};
`ifndef SHARED_BUF_FIXED_PRIO_EN
        ptr_m = (w + 1) % N_REQ;
`endif
      end else begin
        nw = '{v: 0, id: 0, d: 0};
      end
      pipe.push_front(nw);
      void'(pipe.pop_back());
    end
    #1;
  endtask

  logic [N_REQ-1:0] rr_tab [8];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b1;
    bus.req = 4'b1111;
    bus.din = 32'h44332211;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_valid", 32'(bus.dout_valid), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_id", 32'(bus.dout_id), 32'd0);
    rst_n = 1'b1;
    step();
    chk("first_grant", 32'(got_grant), 32'h1);

    // Drain, then latency of a single word.
    bus.req = '0;
    repeat (3) step();
    bus.req = 4'b0100;
    bus.din = 32'h00A50000;
    step();
    bus.req = '0;
    bus.din = '0;
    step();
    step();
    chk("lat_valid", 32'(got_v), 32'd1);
    chk("lat_dout", 32'(got_dout), 32'hA5);
    chk("lat_id", 32'(got_id), 32'd2);
    step();
    chk("lat_after", 32'(got_v), 32'd0);

    // Round-robin with all requests held; ptr sits at 3 after the lone grant to 2.
    model_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
`ifdef SHARED_BUF_FIXED_PRIO_EN
    rr_tab = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    rr_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    bus.req = 4'b1111;
    bus.din = 32'hD3C2B1A0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_seq", 32'(got_grant), 32'(rr_tab[i]));
    end

    // Wrap/skip: drive ptr to 3, then req=0101.
    bus.req = 4'b0111;
    repeat (3) step();
    bus.req = 4'b0101;
    step();
`ifndef SHARED_BUF_FIXED_PRIO_EN
    chk("wrap_g0", 32'(got_grant), 32'h1);
    step();
    chk("wrap_g1", 32'(got_grant), 32'h4);
`endif

    // Stall with one word in flight.
    bus.req = '0;
    repeat (3) step();
    bus.req = 4'b0010;
    bus.din = 32'h00007E00;
    step();
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_grant", 32'(got_grant), 32'd0);
      chk("stall_valid", 32'(got_v), 32'd0);
    end
    bus.en  = 1'b1;
    bus.req = '0;
    step();
    step();
    chk("stall_emerge_v", 32'(got_v), 32'd1);
    chk("stall_emerge_id", 32'(got_id), 32'd1);
    chk("stall_emerge_d", 32'(got_dout), 32'h7E);

    // Reset mid-flight: two words in the buffer.
    bus.req = 4'b1111;
    bus.din = 32'h99887766;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.dout_valid), 32'd0);
    chk("midrst_dout", 32'(bus.dout), 32'd0);
    rst_n = 1'b1;
    model_reset();
    bus.req = '0;
    repeat (3) begin
      step();
      chk("midrst_gone", 32'(got_v), 32'd0);
    end
    bus.req = 4'b1010;
    step();
    chk("midrst_ptr0", 32'(got_grant), 32'h2);

    // Randomized traffic with occasional stalls and one reset pulse.
    for (int i = 0; i < 400; i++) begin
      bus.en  = ($urandom_range(0, 4) != 0);
      bus.req = 4'($urandom_range(0, 15));
      bus.din = $urandom;
      if (i == 200) begin
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
